// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stall/flush sequencer and the datapath.
// master: sequencer side (takes events, drives stage controls); slave: datapath side.
interface pipe_ctrl_if;
  logic hz_stall;
  logic imem_busy;
  logic imem_done;
  logic dmem_busy;
  logic dmem_done;
  logic br_redirect;
  logic halt_wb;

  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic memwb_flush;
  logic fetch_go;

  modport master (
    input  hz_stall, imem_busy, imem_done, dmem_busy, dmem_done, br_redirect, halt_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, memwb_flush, fetch_go
  );

  modport slave (
    output hz_stall, imem_busy, imem_done, dmem_busy, dmem_done, br_redirect, halt_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, memwb_flush, fetch_go
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline with multi-cycle memories: per-stage
// enables and NOP-insert controls, saturating stall counter and memory watchdog.
module pipe_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      bus,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StRun, StDstall, StIdrain, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dstall_req, imem_wait, stop_now;

  assign dstall_req = bus.dmem_busy & ~bus.dmem_done;
  assign imem_wait  = bus.imem_busy & ~bus.imem_done;
  // Watchdog expiry is folded in with HALT so both leave the pipeline frozen.
  assign stop_now   = bus.halt_wb | err_q;

  always_comb begin
    state_d         = state_q;
    err_d           = err_q;
    wd_d            = '0;
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.idex_en     = 1'b1;
    bus.exmem_en    = 1'b1;
    bus.memwb_en    = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.memwb_flush = 1'b0;
    bus.fetch_go    = 1'b1;

    if (rst) begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.idex_en     = 1'b0;
      bus.exmem_en    = 1'b0;
      bus.memwb_en    = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.memwb_flush = 1'b1;
      bus.fetch_go    = 1'b0;
    end else begin
      unique case (state_q)
        StHalt: begin
          bus.pc_en    = 1'b0;
          bus.ifid_en  = 1'b0;
          bus.idex_en  = 1'b0;
          bus.exmem_en = 1'b0;
          bus.memwb_en = 1'b0;
          bus.fetch_go = 1'b0;
        end
        StRun: begin
          if (bus.halt_wb) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
            bus.fetch_go = 1'b0;
            state_d      = StHalt;
          end else if (dstall_req) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_en    = 1'b0;
            bus.memwb_flush = 1'b1;
            bus.fetch_go    = 1'b0;
            state_d         = StDstall;
          end else if (bus.br_redirect) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            // A fetch still in flight belongs to the wrong path; drain it first.
            if (bus.imem_busy) begin
              bus.fetch_go = 1'b0;
              state_d      = StIdrain;
            end
          end else if (bus.hz_stall) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            bus.fetch_go   = 1'b0;
          end else if (imem_wait) begin
            bus.pc_en      = 1'b0;
            bus.ifid_flush = 1'b1;
            bus.fetch_go   = 1'b0;
          end
        end
        StDstall: begin
          if (stop_now) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
            bus.fetch_go = 1'b0;
            state_d      = StHalt;
          end else if (!bus.dmem_done) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_en    = 1'b0;
            bus.memwb_flush = 1'b1;
            bus.fetch_go    = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
        StIdrain: begin
          bus.fetch_go = 1'b0;
          if (stop_now) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
            state_d      = StHalt;
          end else begin
            if (dstall_req) begin
              bus.pc_en       = 1'b0;
              bus.ifid_en     = 1'b0;
              bus.idex_en     = 1'b0;
              bus.exmem_en    = 1'b0;
              bus.memwb_flush = 1'b1;
            end else begin
              bus.pc_en      = 1'b0;
              bus.ifid_flush = 1'b1;
            end
            if (bus.imem_done) begin
              state_d = dstall_req ? StDstall : StRun;
            end
          end
        end
        default: state_d = StRun;
      endcase

      // Consecutive cycles spent frozen on memory, across DSTALL/IDRAIN hand-offs.
      if (TIMEOUT != 0 && !err_q &&
          (state_q == StDstall || state_q == StIdrain) &&
          (state_d == StDstall || state_d == StIdrain)) begin
        wd_d = wd_q + 1'b1;
        if (wd_d == WdW'(TIMEOUT)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.pc_en && state_q != StHalt && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted    = (state_q == StHalt);
  assign err       = err_q;
  assign stall_cnt = cnt_q;

endmodule
